// File: rtl/mode_selector.sv
// Two-button mode selector: synchronised, debounced next/prev buttons step a
// wrapping mode register, with optional hold-to-repeat and a lock input.
module mode_selector #(
   parameter int NUM_MODES       = 3,
   parameter int RESET_MODE      = 0,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int REPEAT_DELAY    = 0,
   parameter int REPEAT_PERIOD   = 250000,
   localparam int MODE_W         = (NUM_MODES > 2) ? $clog2(NUM_MODES) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              btn_next,
   input  logic              btn_prev,
   input  logic              lock,
   output logic [MODE_W-1:0] mode,
   output logic              mode_changed,
   output logic              next_db,
   output logic              prev_db
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

   // Index 0 is the next button, index 1 the prev button throughout.
   logic [1:0]      raw, sync1, sync2, db, db_d, press, rpt, evt;
   logic [DB_W-1:0] db_cnt [2];
   logic            step;
   logic [MODE_W-1:0] mode_nxt;

   assign raw = {btn_prev, btn_next};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         db        <= '0;
         db_d      <= '0;
         db_cnt[0] <= '0;
         db_cnt[1] <= '0;
      end else begin
         db_d <= db;
         for (int i = 0; i < 2; i++) begin
            if (sync2[i] == db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               db[i]     <= sync2[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_W'(1);
            end
         end
      end
   end

   assign press = db & ~db_d;

   generate
      if (REPEAT_DELAY > 0) begin : g_rpt
         localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
         localparam int RPT_W   = $clog2(RPT_MAX + 1);

         logic [1:0]       active, phase, hit, hold_ok;
         logic [RPT_W-1:0] rcnt [2];

         // A button only repeats while it alone is held.
         assign hold_ok = db & ~{db[0], db[1]};

         always_comb begin
            hit = '0;
            for (int i = 0; i < 2; i++) begin
               hit[i] = active[i] &&
                        (rcnt[i] == (phase[i] ? RPT_W'(REPEAT_PERIOD - 1) : RPT_W'(REPEAT_DELAY - 1)));
            end
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               active  <= '0;
               phase   <= '0;
               rcnt[0] <= '0;
               rcnt[1] <= '0;
            end else begin
               for (int i = 0; i < 2; i++) begin
                  if (press[i] && hold_ok[i]) begin
                     active[i] <= 1'b1;
                     phase[i]  <= 1'b0;
                     rcnt[i]   <= '0;
                  end else if (!hold_ok[i]) begin
                     active[i] <= 1'b0;
                     phase[i]  <= 1'b0;
                     rcnt[i]   <= '0;
                  end else if (active[i]) begin
                     if (hit[i]) begin
                        rcnt[i]  <= '0;
                        phase[i] <= 1'b1;
                     end else begin
                        rcnt[i] <= rcnt[i] + RPT_W'(1);
                     end
                  end
               end
            end
         end

         assign rpt = hit & hold_ok;
      end else begin : g_norpt
         assign rpt = '0;
      end
   endgenerate

   assign evt = press | rpt;

   // Simultaneous next and prev cancel; lock drops events outright.
   always_comb begin
      step     = 1'b0;
      mode_nxt = mode;
      if (!lock && (evt[0] ^ evt[1])) begin
         step = 1'b1;
         if ({1'b0, mode} >= (MODE_W + 1)'(NUM_MODES)) begin
            mode_nxt = '0;
         end else if (evt[0]) begin
            mode_nxt = (mode == MODE_W'(NUM_MODES - 1)) ? '0 : mode + MODE_W'(1);
         end else begin
            mode_nxt = (mode == '0) ? MODE_W'(NUM_MODES - 1) : mode - MODE_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode         <= MODE_W'(RESET_MODE);
         mode_changed <= 1'b0;
      end else begin
         mode_changed <= step;
         if (step) begin
            mode <= mode_nxt;
         end
      end
   end

   assign next_db = db[0];
   assign prev_db = db[1];

endmodule

// File: tb/tb_mode_selector.sv
// Bench for mode_selector: three instances (3 modes, 5 modes, 3 modes with
// auto-repeat) share inputs and are checked against an event-level model.
module tb_mode_selector;

   localparam int D = 4;

   logic clk = 1'b0;
   logic rst_n;
   logic btn_next, btn_prev, lock;

   logic [1:0] mode_a, mode_c;
   logic [2:0] mode_b;
   logic chg_a, chg_b, chg_c;
   logic ndb_a, ndb_b, ndb_c, pdb_a, pdb_b, pdb_c;

   int errors = 0;
   int checks = 0;
   bit mdl_on = 1'b0;

   always #5 clk = ~clk;

   mode_selector #(.NUM_MODES(3), .RESET_MODE(0), .DEBOUNCE_CYCLES(D),
                   .REPEAT_DELAY(0), .REPEAT_PERIOD(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .btn_next(btn_next), .btn_prev(btn_prev), .lock(lock),
      .mode(mode_a), .mode_changed(chg_a), .next_db(ndb_a), .prev_db(pdb_a));

   mode_selector #(.NUM_MODES(5), .RESET_MODE(0), .DEBOUNCE_CYCLES(D),
                   .REPEAT_DELAY(0), .REPEAT_PERIOD(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .btn_next(btn_next), .btn_prev(btn_prev), .lock(lock),
      .mode(mode_b), .mode_changed(chg_b), .next_db(ndb_b), .prev_db(pdb_b));

   mode_selector #(.NUM_MODES(3), .RESET_MODE(0), .DEBOUNCE_CYCLES(D),
                   .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) dut_c (
      .clk(clk), .rst_n(rst_n), .btn_next(btn_next), .btn_prev(btn_prev), .lock(lock),
      .mode(mode_c), .mode_changed(chg_c), .next_db(ndb_c), .prev_db(pdb_c));

   int d_mode [3];
   bit d_chg  [3];
   bit d_ndb  [3];
   bit d_pdb  [3];
   always_comb begin
      d_mode[0] = int'(mode_a); d_mode[1] = int'(mode_b); d_mode[2] = int'(mode_c);
      d_chg[0]  = chg_a;        d_chg[1]  = chg_b;        d_chg[2]  = chg_c;
      d_ndb[0]  = ndb_a;        d_ndb[1]  = ndb_b;        d_ndb[2]  = ndb_c;
      d_pdb[0]  = pdb_a;        d_pdb[1]  = pdb_b;        d_pdb[2]  = pdb_c;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Buttons: a level is accepted once the synced input has differed from it
   // for the last D samples. Steps: modular arithmetic on press/repeat events.
   int NM [3] = '{3, 5, 3};
   int RD [3] = '{0, 0, 10};
   int RP [3] = '{1, 1, 3};
   bit ms1 [2], ms2 [2], mdb [2], mdbd [2];
   bit hq0 [$];
   bit hq1 [$];
   int m_mode [3];
   bit m_chg  [3];
   int t0 [3][2];
   int ecount, kk;
   bit m_press [2];
   bit m_ev [2];
   bit m_rep;

   function automatic bit flips(input bit q [$], input bit cur);
      if (q.size() < D) return 1'b0;
      foreach (q[j]) if (q[j] == cur) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++) begin
            ms1[b] = 0; ms2[b] = 0; mdb[b] = 0; mdbd[b] = 0;
         end
         hq0.delete(); hq1.delete();
         for (int i = 0; i < 3; i++) begin
            m_mode[i] = 0; m_chg[i] = 0; t0[i][0] = -1; t0[i][1] = -1;
         end
         ecount = 0;
      end else begin
         ecount++;
         for (int b = 0; b < 2; b++) m_press[b] = mdb[b] && !mdbd[b];
         for (int i = 0; i < 3; i++) begin
            for (int b = 0; b < 2; b++) begin
               m_rep = 0;
               if (RD[i] > 0) begin
                  if (t0[i][b] >= 0) begin
                     if (!mdb[b] || mdb[1-b]) t0[i][b] = -1;
                     else begin
                        kk = ecount - t0[i][b];
                        if (kk == RD[i] || (kk > RD[i] && (kk - RD[i]) % RP[i] == 0)) m_rep = 1;
                     end
                  end
                  if (m_press[b] && !mdb[1-b]) t0[i][b] = ecount;
               end
               m_ev[b] = m_press[b] || m_rep;
            end
            m_chg[i] = !lock && (m_ev[0] != m_ev[1]);
            if (m_chg[i]) m_mode[i] = m_ev[0] ? (m_mode[i] + 1) % NM[i] : (m_mode[i] + NM[i] - 1) % NM[i];
         end
         mdbd[0] = mdb[0]; mdbd[1] = mdb[1];
         hq0.push_back(ms2[0]); if (hq0.size() > D) void'(hq0.pop_front());
         hq1.push_back(ms2[1]); if (hq1.size() > D) void'(hq1.pop_front());
         if (flips(hq0, mdb[0])) mdb[0] = !mdb[0];
         if (flips(hq1, mdb[1])) mdb[1] = !mdb[1];
         ms2[0] = ms1[0]; ms2[1] = ms1[1];
         ms1[0] = btn_next; ms1[1] = btn_prev;
      end
   end

   always @(negedge clk) begin
      if (mdl_on) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("model_mode%0d", i), d_mode[i], m_mode[i]);
            chk($sformatf("model_chg%0d", i), int'(d_chg[i]), int'(m_chg[i]));
            chk($sformatf("model_ndb%0d", i), int'(d_ndb[i]), int'(mdb[0]));
            chk($sformatf("model_pdb%0d", i), int'(d_pdb[i]), int'(mdb[1]));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0; btn_next = 1'b0; btn_prev = 1'b0; lock = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   // Drive a level for 'hold' edges, release for 'rel' edges; count pulses on instance sel.
   task automatic press(input bit nx, input bit pv, input bit lk, input int hold, input int rel,
                        input int sel, output int p_hold, output int p_rel, output int lat);
      @(negedge clk);
      btn_next = nx; btn_prev = pv; lock = lk;
      p_hold = 0; p_rel = 0; lat = -1;
      for (int k = 1; k <= hold + rel; k++) begin
         if (k == hold + 1) begin
            @(negedge clk);
            btn_next = 1'b0; btn_prev = 1'b0; lock = 1'b0;
         end
         @(posedge clk);
         #1;
         if (d_chg[sel]) begin
            if (k <= hold) p_hold++; else p_rel++;
            if (lat < 0) lat = k;
         end
      end
   endtask

   typedef struct {
      string name;
      bit    nx, pv, lk;
      int    hold;
      int    exp_a, exp_b, exp_pulses;
   } vec_t;

   vec_t vecs [9];
   int   exp_b5 [5] = '{1, 2, 3, 4, 0};
   int   exp_rep [6] = '{2, 0, 1, 2, 0, 1};

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ph, pr, lat, pulses, idx;
      bit seen, found;
      int run_n, run_p;

      vecs[0] = '{"prev_a",   0, 1, 0, 20, 0, 3, 1};
      vecs[1] = '{"prev_wrap",0, 1, 0, 20, 2, 2, 1};
      vecs[2] = '{"next_wrap",1, 0, 0, 20, 0, 3, 1};
      vecs[3] = '{"both",     1, 1, 0, 20, 0, 3, 0};
      vecs[4] = '{"locked",   1, 0, 1, 20, 0, 3, 0};
      vecs[5] = '{"glitch3",  1, 0, 0, 3,  0, 3, 0};
      vecs[6] = '{"next1",    1, 0, 0, 20, 1, 4, 1};
      vecs[7] = '{"next2",    1, 0, 0, 20, 2, 0, 1};
      vecs[8] = '{"prev2",    0, 1, 0, 20, 1, 4, 1};

      rst_n = 1'b0; btn_next = 1'b0; btn_prev = 1'b0; lock = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_mode_a", int'(mode_a), 0);
      chk("rst_chg_a", int'(chg_a), 0);
      chk("rst_ndb_a", int'(ndb_a), 0);
      chk("rst_pdb_c", int'(pdb_c), 0);
      #2;
      rst_n = 1'b1;
      mdl_on = 1'b1;

      // Three clean next presses: 0 -> 1 -> 2 -> 0, 7 edges after raw rise.
      for (int n = 0; n < 3; n++) begin
         press(1, 0, 0, 20, 12, 0, ph, pr, lat);
         chk($sformatf("t1_latency%0d", n), lat, 3 + D);
         chk($sformatf("t1_pulses%0d", n), ph, 1);
         chk($sformatf("t1_release%0d", n), pr, 0);
         chk($sformatf("t1_mode%0d", n), int'(mode_a), (n + 1) % 3);
      end

      // Bounce every 2 cycles, then stable high.
      seen = 0; pulses = 0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         btn_next = ((k / 2) % 2 == 0);
         @(posedge clk);
         #1;
         if (ndb_a) seen = 1;
         if (chg_a) pulses++;
      end
      chk("t2_db_bounce", int'(seen), 0);
      chk("t2_pulse_bounce", pulses, 0);
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (chg_a) pulses++;
      end
      chk("t2_one_step", pulses, 1);
      chk("t2_mode", int'(mode_a), 1);
      @(negedge clk);
      btn_next = 1'b0;
      repeat (12) @(negedge clk);

      for (int v = 0; v < 9; v++) begin
         press(vecs[v].nx, vecs[v].pv, vecs[v].lk, vecs[v].hold, 12, 0, ph, pr, lat);
         chk({"vec_pulses_", vecs[v].name}, ph + pr, vecs[v].exp_pulses);
         chk({"vec_mode_a_", vecs[v].name}, int'(mode_a), vecs[v].exp_a);
         chk({"vec_mode_b_", vecs[v].name}, int'(mode_b), vecs[v].exp_b);
      end

      // Lock released while the button is still held: the press is not queued.
      @(negedge clk);
      lock = 1'b1; btn_next = 1'b1;
      pulses = 0;
      for (int k = 0; k < 25; k++) begin
         if (k == 15) begin @(negedge clk); lock = 1'b0; end
         @(posedge clk);
         #1;
         if (chg_a) pulses++;
      end
      @(negedge clk);
      btn_next = 1'b0;
      repeat (12) @(negedge clk);
      chk("t5_no_queue_pulses", pulses, 0);
      chk("t5_no_queue_mode", int'(mode_a), 1);

      // Wrap down from reset, then five next presses on the 5-mode instance.
      do_reset();
      press(0, 1, 0, 20, 12, 0, ph, pr, lat);
      chk("t3_wrap_down_a", int'(mode_a), 2);
      chk("t3_wrap_down_b", int'(mode_b), 4);
      do_reset();
      for (int n = 0; n < 5; n++) begin
         press(1, 0, 0, 20, 12, 1, ph, pr, lat);
         chk($sformatf("t3_b5_mode%0d", n), int'(mode_b), exp_b5[n]);
         chk($sformatf("t3_b5_pulse%0d", n), ph + pr, 1);
      end

      // Auto-repeat interrupted by reset at t0+12.
      do_reset();
      @(negedge clk);
      btn_next = 1'b1;
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(posedge clk);
         #1;
         if (chg_c) found = 1;
      end
      chk("t6a_t0_found", int'(found), 1);
      chk("t6a_t0_mode", int'(mode_c), 1);
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("t6a_chg_k%0d", k), int'(chg_c), int'(k == 10));
         if (k == 10) chk("t6a_mode_k10", int'(mode_c), 2);
      end
      rst_n = 1'b0; btn_next = 1'b0;
      #1;
      chk("t6a_rst_mode", int'(mode_c), 0);
      chk("t6a_rst_chg", int'(chg_c), 0);
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b1;
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         @(posedge clk);
         #1;
         if (chg_c) pulses++;
      end
      chk("t6a_quiet_after_rst", pulses, 0);

      // Full repeat sequence: t0, +10, +13, +16, +19, +22, +25.
      @(negedge clk);
      btn_next = 1'b1;
      found = 0;
      for (int k = 0; k < 20 && !found; k++) begin
         @(posedge clk);
         #1;
         if (chg_c) found = 1;
      end
      chk("t6b_t0_found", int'(found), 1);
      chk("t6b_t0_mode", int'(mode_c), 1);
      idx = 0;
      for (int k = 1; k <= 25; k++) begin
         @(posedge clk);
         #1;
         chk($sformatf("t6b_chg_k%0d", k), int'(chg_c), int'(k >= 10 && (k - 10) % 3 == 0));
         if (k >= 10 && (k - 10) % 3 == 0) begin
            chk($sformatf("t6b_mode_k%0d", k), int'(mode_c), exp_rep[idx]);
            idx++;
         end
      end
      @(negedge clk);
      btn_next = 1'b0;
      repeat (12) @(negedge clk);

      // Random stimulus, checked continuously against the model.
      run_n = 0; run_p = 0;
      for (int k = 0; k < 2500; k++) begin
         @(negedge clk);
         if (run_n == 0) begin btn_next = $urandom_range(0, 1); run_n = $urandom_range(1, 18); end
         if (run_p == 0) begin btn_prev = $urandom_range(0, 1); run_p = $urandom_range(1, 18); end
         run_n--; run_p--;
         if ($urandom_range(0, 19) == 0) lock = ~lock;
      end
      @(negedge clk);
      btn_next = 1'b0; btn_prev = 1'b0; lock = 1'b0;
      repeat (20) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
